// File: rtl/pc_stack_counter_pkg.sv
// Shared definitions for the program counter and its return-address stack:
// command encoding, command priority decode and stack-pointer sizing.
package pc_stack_counter_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD = 3'd0,
        CMD_INC  = 3'd1,
        CMD_RET  = 3'd2,
        CMD_CALL = 3'd3,
        CMD_LOAD = 3'd4
    } cmd_e;

    // sp counts 0..DEPTH inclusive, so it needs one bit more than the index
    function automatic int sp_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Priority load > call > ret > inc > hold
    function automatic cmd_e decode_cmd(input logic load, input logic call,
                                        input logic ret, input logic inc);
        cmd_e cmd;
        if (load) begin
            cmd = CMD_LOAD;
        end else if (call) begin
            cmd = CMD_CALL;
        end else if (ret) begin
            cmd = CMD_RET;
        end else if (inc) begin
            cmd = CMD_INC;
        end else begin
            cmd = CMD_HOLD;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/pc_stack_counter_ret_stack.sv
// ret_stack: DEPTH x WIDTH LIFO of return addresses with top-of-stack read.
// Push while full and pop while empty are ignored; contents are not reset.
module ret_stack
    import pc_stack_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int SPW = sp_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;
    logic [SPW-2:0]   wr_idx_s;
    logic [SPW-2:0]   top_idx_s;

    assign full      = (sp_q == SPW'(DEPTH));
    assign empty     = (sp_q == SPW'(0));
    assign wr_idx_s  = sp_q[SPW-2:0];
    // With sp==DEPTH the low bits wrap to 0, so minus one still lands on DEPTH-1
    assign top_idx_s = sp_q[SPW-2:0] - (SPW-1)'(1);
    assign top       = mem_q[top_idx_s];

    // Stack pointer next-state
    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SPW'(1);
        end else begin
            sp_d = sp_q;
        end
    end

    // Stack pointer register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q <= SPW'(0);
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (rst_n && push && !full) begin
            mem_q[wr_idx_s] <= din;
        end
    end

endmodule

// File: rtl/pc_stack_counter.sv
// Program counter with return-address stack (load/call/ret/inc).
// Define PC_STACK_ERR_EN to add the sticky err output for stack faults.
module pc_stack_counter
    import pc_stack_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned STEP      = 1,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned RESET_VEC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             call,
    input  logic             ret,
    input  logic             inc,
    input  logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] pc,
    output logic             wrap,
    output logic             full,
`ifdef PC_STACK_ERR_EN
    output logic             empty,
    output logic             err
`else
    output logic             empty
`endif
);

    localparam logic [WIDTH-1:0] STEP_W      = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_VEC_W = WIDTH'(RESET_VEC);

    cmd_e             cmd_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] top_s;
    logic             push_s;
    logic             pop_s;
    logic             fault_s;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             wrap_q;
    logic             wrap_d;

    assign cmd_s  = decode_cmd(load, call, ret, inc);
    // Carry out of the MSB drives wrap; the pushed return address ignores it
    assign sum_s  = {1'b0, pc_q} + {1'b0, STEP_W};
    assign push_s = (cmd_s == CMD_CALL);
    assign pop_s  = (cmd_s == CMD_RET);
    assign fault_s = (push_s && full) || (pop_s && empty);

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   (sum_s[WIDTH-1:0]),
        .top   (top_s),
        .full  (full),
        .empty (empty)
    );

    // Next pc and wrap from the decoded command
    always_comb begin
        pc_d   = pc_q;
        wrap_d = 1'b0;
        case (cmd_s)
            CMD_LOAD: pc_d = addr;
            CMD_CALL: pc_d = full ? pc_q : addr;
            CMD_RET:  pc_d = empty ? pc_q : top_s;
            CMD_INC: begin
                pc_d   = sum_s[WIDTH-1:0];
                wrap_d = sum_s[WIDTH];
            end
            CMD_HOLD: pc_d = pc_q;
            default:  pc_d = pc_q;
        endcase
    end

    // pc and wrap registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= RESET_VEC_W;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    assign pc   = pc_q;
    assign wrap = wrap_q;

`ifdef PC_STACK_ERR_EN
    logic err_q;
    logic err_d;

    // Sticky fault flag
    always_comb begin
        err_d = err_q;
        if (fault_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Fault flag register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_fault_s;
    assign unused_fault_s = fault_s;
`endif

endmodule

// File: tb/tb_pc_stack_counter.sv
// Directed self-checking bench for pc_stack_counter (STEP=1 and STEP=4 instances).
// Checks err only when PC_STACK_ERR_EN is defined.
module tb_pc_stack_counter;
    import pc_stack_counter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        load, call, ret, inc;
    logic [15:0] addr;
    logic [15:0] pc;
    logic        wrap, full, empty;
    logic        rst4_n;
    logic        load4, call4, ret4, inc4;
    logic [15:0] addr4;
    logic [15:0] pc4;
    logic        wrap4, full4, empty4;
`ifdef PC_STACK_ERR_EN
    logic        err, err4;
`endif

    int total = 0;
    int bad   = 0;

    pc_stack_counter #(.WIDTH(16), .STEP(1), .DEPTH(8), .RESET_VEC(0)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .call(call), .ret(ret), .inc(inc),
        .addr(addr), .pc(pc), .wrap(wrap), .full(full),
`ifdef PC_STACK_ERR_EN
        .empty(empty), .err(err)
`else
        .empty(empty)
`endif
    );

    pc_stack_counter #(.WIDTH(16), .STEP(4), .DEPTH(8), .RESET_VEC(0)) dut4 (
        .clk(clk), .rst_n(rst4_n), .load(load4), .call(call4), .ret(ret4), .inc(inc4),
        .addr(addr4), .pc(pc4), .wrap(wrap4), .full(full4),
`ifdef PC_STACK_ERR_EN
        .empty(empty4), .err(err4)
`else
        .empty(empty4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one command for one edge, then sample 1 time unit later
    task automatic step(input logic l, input logic c, input logic r, input logic i,
                        input logic [15:0] a);
        load = l; call = c; ret = r; inc = i; addr = a;
        @(posedge clk);
        #1;
        load = 1'b0; call = 1'b0; ret = 1'b0; inc = 1'b0;
    endtask

    task automatic step4(input logic l, input logic i, input logic [15:0] a);
        load4 = l; inc4 = i; addr4 = a;
        @(posedge clk);
        #1;
        load4 = 1'b0; inc4 = 1'b0;
    endtask

    logic [15:0] exp_ret;

    initial begin
        rst_n = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0; inc = 1'b0; addr = 16'h0000;
        rst4_n = 1'b0; load4 = 1'b0; call4 = 1'b0; ret4 = 1'b0; inc4 = 1'b0; addr4 = 16'h0000;

        // 1: reset then inc x3
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", 32'(pc), 32'h0000);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
`ifdef PC_STACK_ERR_EN
        chk("rst_err", 32'(err), 32'h0);
`endif
        rst_n = 1'b1; rst4_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
            chk($sformatf("inc_pc%0d", k), 32'(pc), 32'(k));
        end
        chk("inc_empty", 32'(empty), 32'h1);

        // 2: wrap at top of address space
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFE);
        chk("ld_fffe", 32'(pc), 32'hFFFE);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk("inc_ffff", 32'(pc), 32'hFFFF);
        chk("wrap_lo", 32'(wrap), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk("inc_0000", 32'(pc), 32'h0000);
        chk("wrap_hi", 32'(wrap), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("wrap_pulse", 32'(wrap), 32'h0);
        chk("hold_pc", 32'(pc), 32'h0000);

        // 3: single call/ret
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100);
        chk("call_pc", 32'(pc), 32'h0100);
        chk("call_empty", 32'(empty), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("ret_pc", 32'(pc), 32'h0011);
        chk("ret_empty", 32'(empty), 32'h1);

        // 4: fill stack, overflow, drain in LIFO order, underflow
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h1000);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h2000 + 16'(k));
        end
        chk("fill_pc", 32'(pc), 32'h2007);
        chk("fill_full", 32'(full), 32'h1);
`ifdef PC_STACK_ERR_EN
        chk("fill_err", 32'(err), 32'h0);
`endif
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0200);
        chk("ovf_pc", 32'(pc), 32'h2007);
        chk("ovf_full", 32'(full), 32'h1);
`ifdef PC_STACK_ERR_EN
        chk("ovf_err", 32'(err), 32'h1);
`endif
        for (int k = 7; k >= 0; k--) begin
            exp_ret = (k == 0) ? 16'h1001 : 16'h2000 + 16'(k);
            step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
            chk($sformatf("pop%0d", k), 32'(pc), 32'(exp_ret));
        end
        chk("drain_empty", 32'(empty), 32'h1);
        chk("drain_full", 32'(full), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("unf_pc", 32'(pc), 32'h1001);
`ifdef PC_STACK_ERR_EN
        chk("unf_err", 32'(err), 32'h1);
`endif

        // 5: priority
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0ABC);
        chk("prio_pc", 32'(pc), 32'h0ABC);
        chk("prio_empty", 32'(empty), 32'h1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0300);
        chk("cr_pc", 32'(pc), 32'h0300);
        chk("cr_empty", 32'(empty), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("cr_ret", 32'(pc), 32'h0ABD);

        // 6: reset mid-sequence with sp=3 and call asserted
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0400 + 16'(k));
        end
        chk("sp3_pc", 32'(pc), 32'h0402);
        rst_n = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0500);
        rst_n = 1'b1;
        chk("mrst_pc", 32'(pc), 32'h0000);
        chk("mrst_empty", 32'(empty), 32'h1);
        chk("mrst_wrap", 32'(wrap), 32'h0);
`ifdef PC_STACK_ERR_EN
        chk("mrst_err", 32'(err), 32'h0);
`endif

        // STEP=4 instance
        step4(1'b0, 1'b1, 16'h0000);
        chk("s4_inc", 32'(pc4), 32'h0004);
        chk("s4_nowrap", 32'(wrap4), 32'h0);
        step4(1'b1, 1'b0, 16'hFFFC);
        chk("s4_ld", 32'(pc4), 32'hFFFC);
        step4(1'b0, 1'b1, 16'h0000);
        chk("s4_pc", 32'(pc4), 32'h0000);
        chk("s4_wrap", 32'(wrap4), 32'h1);
        chk("s4_empty", 32'(empty4), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
